matrix_mult_seq: RTL



---
 rtl/matrix_pkg.sv | 18 +
 rtl/matrix_mac.sv | 22 ++
 rtl/matrix_mult_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the time-multiplexed matrix multiplier.
package matrix_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   // Index counter width: clog2 of the dimension, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int elem_off(input int r, input int c, input int stride, input int width);
      return (r * stride + c) * width;
   endfunction

endpackage

// File: rtl/matrix_mac.sv
// Shared multiply-accumulate stage: acc_out = (clear ? 0 : acc_in) + a*b.
module matrix_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 19
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [ACC_WIDTH-1:0]  acc_in,
   input  logic                  clear,
   output logic [ACC_WIDTH-1:0]  acc_out
);

   logic [2*DATA_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]    base;

   always_comb begin
      prod    = a * b;
      base    = clear ? '0 : acc_in;
      acc_out = base + ACC_WIDTH'(prod);
   end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential C = A x B controller: one MAC per clock, row-major over C, inner index fastest.
//
// state | meaning
// IDLE  | waiting for i_calc; o_result/o_ready hold the last job
// CALC  | stepping i/j/k, one multiply-accumulate per edge
module matrix_mult_seq
   import matrix_pkg::*;
#(
   parameter int FIRST_MATRIX_HEIGHT = 5,
   parameter int BOTH_MATRIX_W_H     = 5,
   parameter int SECOND_MATRIX_WIDTH = 5,
   parameter int DATA_WIDTH          = 8,
   parameter int ACC_WIDTH           = 2*DATA_WIDTH + $clog2(BOTH_MATRIX_W_H)
) (
   input  logic                                                    clk,
   input  logic                                                    i_rst,
   input  logic                                                    i_calc,
   input  logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0] i_matrix_1,
   input  logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] i_matrix_2,
   output logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_result,
   output logic                                                    o_ready,
   output logic                                                    o_busy
);

   localparam int M  = FIRST_MATRIX_HEIGHT;
   localparam int K  = BOTH_MATRIX_W_H;
   localparam int N  = SECOND_MATRIX_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int IW = idx_width(M);
   localparam int JW = idx_width(N);
   localparam int KW = idx_width(K);
   localparam logic [IW-1:0] I_LAST = IW'(M - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);

   state_t state, state_nx;

   logic [M*K*DW-1:0]     a_q;
   logic [K*N*DW-1:0]     b_q;
   logic [IW-1:0]         i_idx;
   logic [JW-1:0]         j_idx;
   logic [KW-1:0]         k_idx;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  mac_out;
   logic [DW-1:0]         a_elem;
   logic [DW-1:0]         b_elem;
   logic                  last_i, last_j, last_k;

   assign last_i = (i_idx == I_LAST);
   assign last_j = (j_idx == J_LAST);
   assign last_k = (k_idx == K_LAST);
   assign a_elem = a_q[elem_off(int'(i_idx), int'(k_idx), K, DW) +: DW];
   assign b_elem = b_q[elem_off(int'(k_idx), int'(j_idx), N, DW) +: DW];

   matrix_mac #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .a       (a_elem),
      .b       (b_elem),
      .acc_in  (acc),
      .clear   (k_idx == '0),
      .acc_out (mac_out)
   );

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_calc) state_nx = CALC;
         CALC:    if (last_i && last_j && last_k) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         a_q      <= '0;
         b_q      <= '0;
         i_idx    <= '0;
         j_idx    <= '0;
         k_idx    <= '0;
         acc      <= '0;
         o_result <= '0;
         o_ready  <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_calc) begin
                  a_q     <= i_matrix_1;
                  b_q     <= i_matrix_2;
                  i_idx   <= '0;
                  j_idx   <= '0;
                  k_idx   <= '0;
                  acc     <= '0;
                  o_ready <= 1'b0;
                  o_busy  <= 1'b1;
               end
            end
            CALC: begin
               if (!last_k) begin
                  acc   <= mac_out;
                  k_idx <= k_idx + 1'b1;
               end else begin
                  // Result element is the low DW bits of the finished dot product.
                  o_result[elem_off(int'(i_idx), int'(j_idx), N, DW) +: DW] <= mac_out[DW-1:0];
                  acc   <= '0;
                  k_idx <= '0;
                  if (!last_j) begin
                     j_idx <= j_idx + 1'b1;
                  end else begin
                     j_idx <= '0;
                     if (!last_i) begin
                        i_idx <= i_idx + 1'b1;
                     end else begin
                        i_idx   <= '0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
